// File: rtl/spi_bus_pkg.sv
// ---------------------------------------------------------------------------
// spi_bus_pkg
// Shared constants for the SPI-to-register-bus bridge: frame geometry,
// header field positions, timing parameter defaults and the FSM state type.
// Optional feature macro used by the design: SPI_BUS_READ_EN (read path).
// ---------------------------------------------------------------------------
package spi_bus_pkg;

    // Frame geometry: 24 header bits then 32 data bits, MSB first.
    localparam int FRAME_LEN = 56;
    localparam int HDR_LEN   = 24;
    localparam int DATA_LEN  = FRAME_LEN - HDR_LEN;

    // Field positions inside the 24-bit header.
    localparam int HDR_RD_BIT   = 23;
    localparam int HDR_BE_LSB   = 16;
    localparam int BE_W         = 4;
    localparam int HDR_ADDR_LSB = 0;
    localparam int ADDR_W       = 12;

    // Synchronizer depth and width of the bus-phase cycle counter.
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 16;

    // Parameter defaults for the top level.
    localparam int DEF_WR_PULSE = 2;
    localparam int DEF_SETUP    = 1;
    localparam int DEF_RD_WAIT  = 2;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_HDR     = 4'd1,
        ST_WDATA   = 4'd2,
        ST_WSETUP  = 4'd3,
        ST_WSTROBE = 4'd4,
        ST_WHOLD   = 4'd5,
        ST_RSETUP  = 4'd6,
        ST_RSHIFT  = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

endpackage

// File: rtl/spi_bus_sync.sv
// ---------------------------------------------------------------------------
// spi_bus_sync
// Brings the asynchronous SPI slave inputs into the clk domain through
// two-flop synchronizers and derives single-cycle edge pulses.
// Ports:
//   i_clk, i_reset        system clock, synchronous active-high reset
//   i_sclk, i_csn, i_mosi raw SPI pins
//   o_sclk_rise/fall      one-cycle pulses on synchronized sclk edges
//   o_csn_fall/rise       one-cycle pulses on synchronized csn edges
//   o_csn, o_mosi         synchronized levels (aligned with the edge pulses)
// ---------------------------------------------------------------------------
import spi_bus_pkg::*;

module spi_bus_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sclk,
    input  logic i_csn,
    input  logic i_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_csn_fall,
    output logic o_csn_rise,
    output logic o_csn,
    output logic o_mosi
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_csn_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_csn_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sclk_sync <= '0;
            r_csn_sync  <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_csn_prev  <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], i_csn};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_csn_prev  <= r_csn_sync[SYNC_STAGES-1];
        end
    end

    // mosi goes through the same depth as sclk, so the synchronized data bit
    // is valid in the cycle the rising-edge pulse fires.
    assign o_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
    assign o_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;
    assign o_csn_fall  = ~r_csn_sync[SYNC_STAGES-1] & r_csn_prev;
    assign o_csn_rise  = r_csn_sync[SYNC_STAGES-1] & ~r_csn_prev;
    assign o_csn       = r_csn_sync[SYNC_STAGES-1];
    assign o_mosi      = r_mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_bus_master.sv
// ---------------------------------------------------------------------------
// spi_bus_master
// SPI mode-0 slave that turns each 56-bit frame into one register-bus access.
// Header (24 bits): [23] rd, [19:16] byteEn, [11:0] addr; 32 data bits follow.
// Writes drive busCs/busAddr/busDataOut, then pulse busWr0..3 per byteEn.
// Reads drive busCs/busAddr, capture busDataIn and shift it out on miso.
// Optional feature macro: SPI_BUS_READ_EN. When undefined, read frames are
// consumed without bus activity and miso is tied to 0.
// Parameters:
//   WR_PULSE  strobe width in clk cycles            (>= 1)
//   SETUP     cs/addr/data setup and hold cycles    (>= 1)
//   RD_WAIT   cycles from busCs/busAddr to capture  (>= 1)
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   sclk, csn, mosi        asynchronous SPI inputs (csn active low)
//   miso                   SPI read data
//   busCs, busAddr         register-bus chip select and address
//   busDataOut, busDataIn  register-bus write / read data
//   busWr0..busWr3         byte write strobes, falling edge commits
// ---------------------------------------------------------------------------
import spi_bus_pkg::*;

module spi_bus_master #(
    parameter int WR_PULSE = DEF_WR_PULSE,
    parameter int SETUP    = DEF_SETUP,
    parameter int RD_WAIT  = DEF_RD_WAIT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sclk,
    input  logic                csn,
    input  logic                mosi,
    output logic                miso,
    output logic                busCs,
    output logic [ADDR_W-1:0]   busAddr,
    output logic [DATA_LEN-1:0] busDataOut,
    input  logic [DATA_LEN-1:0] busDataIn,
    output logic                busWr0,
    output logic                busWr1,
    output logic                busWr2,
    output logic                busWr3
);

    localparam logic [5:0]       HDR_LAST   = 6'(HDR_LEN - 1);
    localparam logic [5:0]       DATA_LAST  = 6'(DATA_LEN - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(WR_PULSE - 1);

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_csn_fall;
    logic w_csn_rise;
    logic w_csn;
    logic w_mosi;

    spi_bus_sync u_sync (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_sclk      (sclk),
        .i_csn       (csn),
        .i_mosi      (mosi),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_csn_fall  (w_csn_fall),
        .o_csn_rise  (w_csn_rise),
        .o_csn       (w_csn),
        .o_mosi      (w_mosi)
    );

    state_t                r_state;
    logic [5:0]            r_bit_cnt;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_LEN-1:0]   r_shift;
    logic [BE_W-1:0]       r_be;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_bus_cs;
    logic [ADDR_W-1:0]     r_bus_addr;
    logic [DATA_LEN-1:0]   r_bus_dout;
    logic [BE_W-1:0]       r_bus_wr;
    logic [DATA_LEN-1:0]   w_shift_next;

`ifdef SPI_BUS_READ_EN
    localparam logic [CNT_W-1:0] RDW_LAST = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] RDW_END  = CNT_W'(RD_WAIT);
    logic [DATA_LEN-1:0] r_rdata;
    logic                r_miso;
    // Set on entering the read: the sclk fall closing header bit 23 still
    // has to pass before shifting starts, since bit 31 must be presented for
    // the first data rising edge.
    logic                r_fall_pend;
`endif

    assign w_shift_next = {r_shift[DATA_LEN-2:0], w_mosi};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_be       <= '0;
            r_addr     <= '0;
            r_bus_cs   <= 1'b0;
            r_bus_addr <= '0;
            r_bus_dout <= '0;
            r_bus_wr   <= '0;
`ifdef SPI_BUS_READ_EN
            r_rdata     <= '0;
            r_miso      <= 1'b0;
            r_fall_pend <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_csn_fall) begin
                        r_state   <= ST_HDR;
                        r_bit_cnt <= '0;
                    end
                end

                ST_HDR: begin
                    if (w_csn_rise) begin
                        r_state <= ST_IDLE;
                    end else if (w_sclk_rise) begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == HDR_LAST) begin
                            r_bit_cnt <= '0;
                            r_cnt     <= '0;
                            r_be      <= w_shift_next[HDR_BE_LSB +: BE_W];
                            r_addr    <= w_shift_next[HDR_ADDR_LSB +: ADDR_W];
                            if (w_shift_next[HDR_RD_BIT]) begin
`ifdef SPI_BUS_READ_EN
                                r_state     <= ST_RSETUP;
                                r_bus_cs    <= 1'b1;
                                r_bus_addr  <= w_shift_next[HDR_ADDR_LSB +: ADDR_W];
                                r_fall_pend <= 1'b1;
`else
                                r_state <= ST_DONE;
`endif
                            end else begin
                                r_state <= ST_WDATA;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                        end
                    end
                end

                ST_WDATA: begin
                    if (w_csn_rise) begin
                        r_state <= ST_IDLE;
                    end else if (w_sclk_rise) begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == DATA_LAST) begin
                            r_state    <= ST_WSETUP;
                            r_cnt      <= '0;
                            r_bus_cs   <= 1'b1;
                            r_bus_addr <= r_addr;
                            r_bus_dout <= w_shift_next;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                        end
                    end
                end

                // From here on the write runs to completion regardless of csn.
                ST_WSETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_state  <= ST_WSTROBE;
                        r_cnt    <= '0;
                        r_bus_wr <= r_be;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_WSTROBE: begin
                    if (r_cnt == PULSE_LAST) begin
                        r_state  <= ST_WHOLD;
                        r_cnt    <= '0;
                        r_bus_wr <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_WHOLD: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_state  <= ST_DONE;
                        r_cnt    <= '0;
                        r_bus_cs <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

`ifdef SPI_BUS_READ_EN
                ST_RSETUP: begin
                    if (w_csn_rise) begin
                        r_state  <= ST_IDLE;
                        r_bus_cs <= 1'b0;
                        r_miso   <= 1'b0;
                    end else begin
                        if (w_sclk_fall) begin
                            r_fall_pend <= 1'b0;
                        end
                        if (r_cnt == RDW_LAST) begin
                            r_rdata <= busDataIn;
                            r_cnt   <= r_cnt + 1'b1;
                        end else if (r_cnt == RDW_END) begin
                            r_state  <= ST_RSHIFT;
                            r_bus_cs <= 1'b0;
                            r_miso   <= r_rdata[DATA_LEN-1];
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                ST_RSHIFT: begin
                    if (w_csn_rise) begin
                        r_state <= ST_IDLE;
                        r_miso  <= 1'b0;
                    end else if (w_sclk_fall) begin
                        if (r_fall_pend) begin
                            r_fall_pend <= 1'b0;
                        end else begin
                            r_miso  <= r_rdata[DATA_LEN-2];
                            r_rdata <= {r_rdata[DATA_LEN-2:0], 1'b0};
                        end
                    end
                end
`endif

                // Level test rather than edge: a completing write may still be
                // on the bus when csn rises, so the edge can be gone by now.
                ST_DONE: begin
                    if (w_csn) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busCs      = r_bus_cs;
    assign busAddr    = r_bus_addr;
    assign busDataOut = r_bus_dout;
    assign busWr0     = r_bus_wr[0];
    assign busWr1     = r_bus_wr[1];
    assign busWr2     = r_bus_wr[2];
    assign busWr3     = r_bus_wr[3];

`ifdef SPI_BUS_READ_EN
    assign miso = r_miso;
`else
    // Read-side inputs have no consumer in this build.
    logic w_unused;
    assign w_unused = ^{busDataIn, w_sclk_fall, (RD_WAIT > 0)};
    assign miso     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_bus_master.sv
`timescale 1ns/1ps
module tb_spi_bus_master;

    localparam int WR_PULSE = 2;
    localparam int SETUP    = 1;
    localparam int RD_WAIT  = 2;
    localparam int CS_WR    = 2 * SETUP + WR_PULSE;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        csn;
    logic        mosi;
    logic        miso;
    logic        busCs;
    logic [11:0] busAddr;
    logic [31:0] busDataOut;
    logic [31:0] busDataIn;
    logic        busWr0, busWr1, busWr2, busWr3;

    int checks = 0;
    int errors = 0;

    // Clock / reset
    always #5 clk = ~clk;

    spi_bus_master #(
        .WR_PULSE (WR_PULSE),
        .SETUP    (SETUP),
        .RD_WAIT  (RD_WAIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sclk       (sclk),
        .csn        (csn),
        .mosi       (mosi),
        .miso       (miso),
        .busCs      (busCs),
        .busAddr    (busAddr),
        .busDataOut (busDataOut),
        .busDataIn  (busDataIn),
        .busWr0     (busWr0),
        .busWr1     (busWr1),
        .busWr2     (busWr2),
        .busWr3     (busWr3)
    );

    // Observed bus cycle, one per busCs high window
    typedef struct packed {
        logic [11:0]     addr;
        logic [31:0]     data;
        logic [3:0]      mask;
        logic [7:0]      cs_cycles;
        logic [7:0]      lead;
        logic [7:0]      trail;
        logic [3:0][7:0] pw;
        logic            stable;
    } txn_t;

    // Scoreboard: expected {byteEn, addr, data} pushed at stimulus time
    logic [47:0] exp_q[$];
    txn_t        obs_q[$];

    txn_t cur;
    bit   mon_active  = 0;
    bit   seen_wr     = 0;
    int   strobe_no_cs = 0;

    always @(negedge clk) begin
        logic [3:0] wr;
        wr = {busWr3, busWr2, busWr1, busWr0};
        if (reset) begin
            mon_active = 0;
        end else begin
            if (!busCs && wr != 4'h0) strobe_no_cs++;
            if (busCs) begin
                if (!mon_active) begin
                    cur        = '0;
                    cur.addr   = busAddr;
                    cur.data   = busDataOut;
                    cur.stable = 1'b1;
                    mon_active = 1;
                    seen_wr    = 0;
                end
                cur.cs_cycles = cur.cs_cycles + 8'd1;
                if (busAddr !== cur.addr || busDataOut !== cur.data) cur.stable = 1'b0;
                cur.mask = cur.mask | wr;
                for (int n = 0; n < 4; n++) begin
                    if (wr[n]) cur.pw[n] = cur.pw[n] + 8'd1;
                end
                if (wr != 4'h0) begin
                    seen_wr   = 1;
                    cur.trail = '0;
                end else if (seen_wr) begin
                    cur.trail = cur.trail + 8'd1;
                end else begin
                    cur.lead = cur.lead + 8'd1;
                end
            end else if (mon_active) begin
                obs_q.push_back(cur);
                mon_active = 0;
            end
        end
    end

    // Driver tasks
    function automatic logic [55:0] mk_frame(input logic rd, input logic [2:0] j3,
                                             input logic [3:0] be, input logic [3:0] j4,
                                             input logic [11:0] addr, input logic [31:0] data);
        return {rd, j3, be, j4, addr, data};
    endfunction

    // Mode 0 master at clk/8; miso sampled at each sclk rising edge.
    task automatic send_frame(input logic [55:0] frame, input int nbits,
                              input bit end_frame, output logic [55:0] rx);
        rx = '0;
        @(negedge clk);
        csn = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = frame[55-i];
            repeat (4) @(negedge clk);
            rx   = {rx[54:0], miso};
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        mosi = 1'b0;
        if (end_frame) begin
            repeat (4) @(negedge clk);
            csn = 1'b1;
            repeat (12) @(negedge clk);
        end
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 0;
        for (int c = 0; c < 300 && !ok; c++) begin
            if (obs_q.size() >= n) ok = 1;
            else @(negedge clk);
        end
    endtask

    // Tests
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busCs, busWr3, busWr2, busWr1, busWr0, miso} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000", {busCs, busWr3, busWr2, busWr1, busWr0, miso});
        end
        checks++;
        if (busAddr !== 12'h000) begin
            errors++;
            $display("FAIL reset_addr got %h want 000", busAddr);
        end
        checks++;
        if (busDataOut !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 00000000", busDataOut);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    localparam logic [11:0] T_ADDR [3] = '{12'h123, 12'h7A5, 12'h800};
    localparam logic [3:0]  T_BE   [3] = '{4'hF, 4'h5, 4'h0};
    localparam logic [31:0] T_DATA [3] = '{32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D};
    localparam logic [2:0]  T_J3   [3] = '{3'b000, 3'b101, 3'b011};
    localparam logic [3:0]  T_J4   [3] = '{4'h0, 4'hA, 4'h6};

    task automatic test_write_cases();
        logic [55:0] rx;
        logic [47:0] e;
        txn_t        o;
        bit          ok;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({T_BE[k], T_ADDR[k], T_DATA[k]});
            send_frame(mk_frame(1'b0, T_J3[k], T_BE[k], T_J4[k], T_ADDR[k], T_DATA[k]), 56, 1, rx);
            wait_obs(1, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL write%0d_timeout got no bus cycle want one", k);
                void'(exp_q.pop_front());
            end else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if ({o.mask, o.addr, o.data} !== e) begin
                    errors++;
                    $display("FAIL write%0d_key got %h want %h", k, {o.mask, o.addr, o.data}, e);
                end
                checks++;
                if (o.cs_cycles !== 8'(CS_WR)) begin
                    errors++;
                    $display("FAIL write%0d_cs_len got %0d want %0d", k, o.cs_cycles, CS_WR);
                end
                checks++;
                if (o.stable !== 1'b1) begin
                    errors++;
                    $display("FAIL write%0d_stable got %b want 1", k, o.stable);
                end
                for (int n = 0; n < 4; n++) begin
                    checks++;
                    if (o.pw[n] !== (e[44+n] ? 8'(WR_PULSE) : 8'd0)) begin
                        errors++;
                        $display("FAIL write%0d_pw%0d got %0d want %0d", k, n, o.pw[n],
                                 e[44+n] ? WR_PULSE : 0);
                    end
                end
                checks++;
                if (e[47:44] != 4'h0) begin
                    if (o.lead !== 8'(SETUP) || o.trail !== 8'(SETUP)) begin
                        errors++;
                        $display("FAIL write%0d_setup_hold got %0d/%0d want %0d/%0d", k, o.lead, o.trail, SETUP, SETUP);
                    end
                end else if (o.lead !== 8'(CS_WR)) begin
                    errors++;
                    $display("FAIL write%0d_nostrobe_lead got %0d want %0d", k, o.lead, CS_WR);
                end
            end
            checks++;
            if (rx !== 56'h0) begin
                errors++;
                $display("FAIL write%0d_miso got %h want 0", k, rx);
            end
        end
    endtask

    task automatic test_abort();
        logic [55:0] rx;
        txn_t        o;
        bit          ok;
        send_frame(mk_frame(1'b0, 3'b0, 4'hF, 4'h0, 12'h3C0, 32'h55AA55AA), 40, 1, rx);
        repeat (20) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL abort_no_bus got %0d cycles want 0", obs_q.size());
            obs_q.delete();
        end
        exp_q.push_back({4'h3, 12'h3C1, 32'h0BADF00D});
        send_frame(mk_frame(1'b0, 3'b0, 4'h3, 4'h0, 12'h3C1, 32'h0BADF00D), 56, 1, rx);
        wait_obs(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_next_timeout got no bus cycle want one");
            void'(exp_q.pop_front());
        end else begin
            o = obs_q.pop_front();
            checks++;
            if ({o.mask, o.addr, o.data} !== exp_q.pop_front()) begin
                errors++;
                $display("FAIL abort_next_key got %h want %h", {o.mask, o.addr, o.data}, 48'h3_3C1_0BADF00D);
            end
            checks++;
            if (o.pw[0] !== 8'(WR_PULSE) || o.pw[1] !== 8'(WR_PULSE)) begin
                errors++;
                $display("FAIL abort_next_pw got %0d/%0d want %0d", o.pw[0], o.pw[1], WR_PULSE);
            end
        end
    endtask

    task automatic test_reset_mid_strobe();
        logic [55:0] rx;
        txn_t        o;
        bit          found;
        bit          ok;
        send_frame(mk_frame(1'b0, 3'b0, 4'hF, 4'h0, 12'h0AB, 32'hFFFF0000), 56, 0, rx);
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if ({busWr3, busWr2, busWr1, busWr0} != 4'h0) found = 1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_strobe_seen got none want strobe");
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busCs, busWr3, busWr2, busWr1, busWr0, busAddr, busDataOut, miso} !== 50'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs got %h want 0",
                     {busCs, busWr3, busWr2, busWr1, busWr0, busAddr, busDataOut, miso});
        end
        @(negedge clk);
        reset = 1'b0;
        csn   = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL rst_partial got %0d cycles want 0", obs_q.size());
            obs_q.delete();
        end
        exp_q.push_back({4'hC, 12'h0AC, 32'h13579BDF});
        send_frame(mk_frame(1'b0, 3'b0, 4'hC, 4'h0, 12'h0AC, 32'h13579BDF), 56, 1, rx);
        wait_obs(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_next_timeout got no bus cycle want one");
            void'(exp_q.pop_front());
        end else begin
            o = obs_q.pop_front();
            checks++;
            if ({o.mask, o.addr, o.data} !== exp_q.pop_front()) begin
                errors++;
                $display("FAIL rst_next_key got %h want %h", {o.mask, o.addr, o.data}, 48'hC_0AC_13579BDF);
            end
        end
    endtask

    task automatic test_read();
        logic [55:0] rx;
`ifdef SPI_BUS_READ_EN
        txn_t o;
        bit   ok;
        busDataIn = 32'hA5A50F0F;
        send_frame(mk_frame(1'b1, 3'b0, 4'h0, 4'h0, 12'h040, 32'h0), 56, 1, rx);
        wait_obs(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL read_timeout got no bus cycle want one");
        end else begin
            o = obs_q.pop_front();
            checks++;
            if (o.addr !== 12'h040 || o.mask !== 4'h0) begin
                errors++;
                $display("FAIL read_addr got %h/%h want 040/0", o.addr, o.mask);
            end
            checks++;
            if (o.cs_cycles !== 8'(RD_WAIT + 1)) begin
                errors++;
                $display("FAIL read_cs_len got %0d want %0d", o.cs_cycles, RD_WAIT + 1);
            end
        end
        checks++;
        if (rx !== {24'h0, 32'hA5A50F0F}) begin
            errors++;
            $display("FAIL read_miso got %h want %h", rx, {24'h0, 32'hA5A50F0F});
        end
`else
        busDataIn = 32'hA5A50F0F;
        send_frame(mk_frame(1'b1, 3'b0, 4'hF, 4'h0, 12'h040, 32'hFFFFFFFF), 56, 1, rx);
        repeat (20) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL read_disabled_bus got %0d cycles want 0", obs_q.size());
            obs_q.delete();
        end
        checks++;
        if (rx !== 56'h0) begin
            errors++;
            $display("FAIL read_disabled_miso got %h want 0", rx);
        end
`endif
        checks++;
        if (miso !== 1'b0) begin
            errors++;
            $display("FAIL read_miso_idle got %b want 0", miso);
        end
    endtask

    task automatic test_back_to_back();
        logic [55:0] rx;
        logic [11:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [47:0] e;
        txn_t        o;
        bit          ok;
        for (int k = 0; k < 4; k++) begin
            a = 12'($urandom_range(0, 4095));
            b = 4'($urandom_range(0, 15));
            d = $urandom();
            exp_q.push_back({b, a, d});
            send_frame(mk_frame(1'b0, 3'b0, b, 4'h0, a, d), 56, 1, rx);
        end
        wait_obs(4, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout got %0d cycles want 4", obs_q.size());
            exp_q.delete();
            obs_q.delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if ({o.mask, o.addr, o.data} !== e) begin
                    errors++;
                    $display("FAIL b2b%0d_key got %h want %h", k, {o.mask, o.addr, o.data}, e);
                end
                checks++;
                if (o.cs_cycles !== 8'(CS_WR) || o.stable !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b%0d_timing got %0d/%b want %0d/1", k, o.cs_cycles, o.stable, CS_WR);
                end
            end
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (strobe_no_cs != 0) begin
            errors++;
            $display("FAIL strobe_without_cs got %0d want 0", strobe_no_cs);
        end
        checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d/%0d want 0/0", exp_q.size(), obs_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        sclk      = 1'b0;
        csn       = 1'b1;
        mosi      = 1'b0;
        busDataIn = 32'h0;
        test_reset();
        test_write_cases();
        test_abort();
        test_reset_mid_strobe();
        test_read();
        test_back_to_back();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
